// File: rtl/controle_entrada_saida_pkg.sv
// Shared command codes, FSM encoding and BCD helpers for the I/O controller.
package controle_entrada_saida_pkg;

  localparam logic [1:0] CMD_NENHUM = 2'b00;
  localparam logic [1:0] CMD_IN     = 2'b01;
  localparam logic [1:0] CMD_OUT    = 2'b10;

  localparam int unsigned MAX_DISPLAY = 999;
  localparam int unsigned BITS_BCD    = 10;

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    ESPERA_SOLTA = 3'd1,
    ESPERA_BOTAO = 3'd2,
    CONVERTE     = 3'd3,
    ATUALIZA     = 3'd4,
    LIBERA       = 3'd5
  } estado_t;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
  function automatic logic [11:0] passo_dabble(input logic [11:0] acc, input logic bitEntrada);
    logic [11:0] ajustado;
    for (int i = 0; i < 3; i++) begin
      ajustado[i*4 +: 4] = (acc[i*4 +: 4] >= 4'd5) ? acc[i*4 +: 4] + 4'd3 : acc[i*4 +: 4];
    end
    return {ajustado[10:0], bitEntrada};
  endfunction

endpackage

// File: rtl/controle_entrada_saida_conversor.sv
// Serial double-dabble converter: start loads bin, then one step per cycle for BITS_BCD cycles.
module conversor_bcd_serial
  import controle_entrada_saida_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [BITS_BCD-1:0] bin,
  output logic                pronto,
  output logic [11:0]         bcd
);

  logic [BITS_BCD-1:0] desloc;
  logic [3:0]          cnt;
  logic                ocupado;

  // High during the cycle whose step is the last one, so the caller can leave on that edge.
  assign pronto = ocupado && (cnt == 4'(BITS_BCD - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      desloc  <= '0;
      cnt     <= '0;
      ocupado <= 1'b0;
      bcd     <= '0;
    end else if (start) begin
      desloc  <= bin;
      cnt     <= '0;
      ocupado <= 1'b1;
      bcd     <= '0;
    end else if (ocupado) begin
      bcd    <= passo_dabble(bcd, desloc[BITS_BCD-1]);
      desloc <= {desloc[BITS_BCD-2:0], 1'b0};
      cnt    <= cnt + 4'd1;
      if (pronto) begin
        ocupado <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/controle_entrada_saida.sv
// I/O controller: stalls the CPU for IN (button capture of switches) and OUT (BCD display update).
module controle_entrada_saida
  import controle_entrada_saida_pkg::*;
#(
  parameter int LARGURA_DADO   = 32,
  parameter int LARGURA_CHAVES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                entradaSaidaControl,
  input  logic [LARGURA_DADO-1:0]   dadosEscrita,
  input  logic [LARGURA_CHAVES-1:0] entradaDeDados,
  input  logic                      botaoIN,
  output logic [LARGURA_DADO-1:0]   DadosLidos,
  output logic                      pausa,
  output logic [3:0]                unidade,
  output logic [3:0]                dezena,
  output logic [3:0]                centena,
  output logic                      estouro,
  output estado_t                   estadoDebug
);

  estado_t             estado, proximo;
  logic                botaoAnt, sobe;
  logic                iniciaConv, capturaChaves, confirma, ocupa;
  logic                estouroPend;
  logic                convPronto;
  logic [11:0]         convBcd;
  logic [BITS_BCD-1:0] binEntrada;

  assign sobe        = botaoIN & ~botaoAnt;
  assign estadoDebug = estado;
  assign binEntrada  = (dadosEscrita > LARGURA_DADO'(MAX_DISPLAY)) ? BITS_BCD'(MAX_DISPLAY)
                                                                   : dadosEscrita[BITS_BCD-1:0];

  // Stall handshake: pausa is high from the cycle an IN/OUT command is seen until its result
  // is committed; the CPU holds the command while stalled and must drop it to 00/11 before the
  // next command is accepted, so a static command is serviced exactly once.
  assign pausa = reset & ocupa;

  conversor_bcd_serial u_conversor (
    .clock  (clock),
    .reset  (reset),
    .start  (iniciaConv),
    .bin    (binEntrada),
    .pronto (convPronto),
    .bcd    (convBcd)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo       = estado;
    iniciaConv    = 1'b0;
    capturaChaves = 1'b0;
    confirma      = 1'b0;
    ocupa         = 1'b0;
    case (estado)
      OCIOSO: begin
        if (entradaSaidaControl == CMD_IN) begin
          ocupa   = 1'b1;
          proximo = ESPERA_SOLTA;
        end else if (entradaSaidaControl == CMD_OUT) begin
          ocupa      = 1'b1;
          iniciaConv = 1'b1;
          proximo    = CONVERTE;
        end
      end
      ESPERA_SOLTA: begin
        ocupa = 1'b1;
        if (!botaoIN) proximo = ESPERA_BOTAO;
      end
      ESPERA_BOTAO: begin
        ocupa = 1'b1;
        if (sobe) begin
          capturaChaves = 1'b1;
          proximo       = LIBERA;
        end
      end
      CONVERTE: begin
        ocupa = 1'b1;
        if (convPronto) proximo = ATUALIZA;
      end
      ATUALIZA: begin
        ocupa    = 1'b1;
        confirma = 1'b1;
        proximo  = LIBERA;
      end
      LIBERA: begin
        if (entradaSaidaControl != CMD_IN && entradaSaidaControl != CMD_OUT) proximo = OCIOSO;
      end
      default: proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botaoAnt    <= 1'b0;
      DadosLidos  <= '0;
      estouroPend <= 1'b0;
      unidade     <= '0;
      dezena      <= '0;
      centena     <= '0;
      estouro     <= 1'b0;
    end else begin
      botaoAnt <= botaoIN;
      if (iniciaConv) begin
        estouroPend <= (dadosEscrita > LARGURA_DADO'(MAX_DISPLAY));
      end
      if (capturaChaves) begin
        DadosLidos <= {{(LARGURA_DADO-LARGURA_CHAVES){1'b0}}, entradaDeDados};
      end
      // Digits and overflow change together so the display never shows a half-converted value.
      if (confirma) begin
        unidade <= convBcd[3:0];
        dezena  <= convBcd[7:4];
        centena <= convBcd[11:8];
        estouro <= estouroPend;
      end
    end
  end

endmodule

// File: tb/tb_controle_entrada_saida.sv
// Directed bench for controle_entrada_saida with a scoreboard popped on every stall release.
module tb_controle_entrada_saida;
  import controle_entrada_saida_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  entradaSaidaControl = CMD_NENHUM;
  logic [31:0] dadosEscrita = '0;
  logic [3:0]  entradaDeDados = '0;
  logic        botaoIN = 1'b0;
  logic [31:0] DadosLidos;
  logic        pausa;
  logic [3:0]  unidade, dezena, centena;
  logic        estouro;
  estado_t     estadoDebug;

  int checks = 0;
  int errors = 0;

  // Expected {DadosLidos, centena, dezena, unidade, estouro} at each stall release.
  logic [44:0] exp_q[$];
  logic [31:0] m_dl  = '0;
  logic [11:0] m_bcd = '0;
  logic        m_est = 1'b0;
  logic        pausaAnt = 1'b0;

  controle_entrada_saida dut (
    .clock               (clock),
    .reset               (reset),
    .entradaSaidaControl (entradaSaidaControl),
    .dadosEscrita        (dadosEscrita),
    .entradaDeDados      (entradaDeDados),
    .botaoIN             (botaoIN),
    .DadosLidos          (DadosLidos),
    .pausa               (pausa),
    .unidade             (unidade),
    .dezena              (dezena),
    .centena             (centena),
    .estouro             (estouro),
    .estadoDebug         (estadoDebug)
  );

  always #5 clock = ~clock;

  task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  always @(negedge clock) begin
    logic [44:0] e;
    if (reset && pausaAnt && !pausa) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_release: got release expected none");
      end else begin
        e = exp_q.pop_front();
        check("sb_dadoslidos", 64'(DadosLidos), 64'(e[44:13]));
        check("sb_digits", 64'({centena, dezena, unidade}), 64'(e[12:1]));
        check("sb_estouro", 64'(estouro), 64'(e[0]));
      end
    end
    pausaAnt = reset ? pausa : 1'b0;
  end

  task automatic run_out(input logic [31:0] v, input logic [11:0] eb, input logic ee, input int hold);
    int n;
    @(posedge clock); #1;
    exp_q.push_back({m_dl, eb, ee});
    entradaSaidaControl = CMD_OUT;
    dadosEscrita = v;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (!pausa) break;
      n++;
      check("out_no_partial", 64'({centena, dezena, unidade, estouro}), 64'({m_bcd, m_est}));
    end
    check("out_stall_cycles", 64'(n), 64'(12));
    m_bcd = eb;
    m_est = ee;
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      check("out_held_pausa", 64'(pausa), 64'(0));
      check("out_held_state", 64'(estadoDebug), 64'(LIBERA));
    end
    entradaSaidaControl = CMD_NENHUM;
  endtask

  task automatic run_in(input logic [3:0] sw, input int hold);
    @(posedge clock); #1;
    exp_q.push_back({28'd0, sw, m_bcd, m_est});
    entradaSaidaControl = CMD_IN;
    entradaDeDados = sw;
    repeat (2) @(posedge clock);
    #1 botaoIN = 1'b1;
    @(negedge clock);
    check("in_pausa_press", 64'(pausa), 64'(1));
    @(negedge clock);
    check("in_pausa_drop", 64'(pausa), 64'(0));
    m_dl = {28'd0, sw};
    for (int k = 0; k < hold; k++) begin
      @(posedge clock); #1;
      botaoIN = ~botaoIN;
      entradaDeDados = 4'hC;
      @(negedge clock);
      check("libera_pausa", 64'(pausa), 64'(0));
      check("libera_dadoslidos", 64'(DadosLidos), 64'(m_dl));
      check("libera_state", 64'(estadoDebug), 64'(LIBERA));
    end
    entradaSaidaControl = CMD_NENHUM;
    botaoIN = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_dadoslidos", 64'(DadosLidos), 64'(0));
    check("rst_digits", 64'({centena, dezena, unidade}), 64'(0));
    check("rst_estouro", 64'(estouro), 64'(0));
    check("rst_pausa", 64'(pausa), 64'(0));
    check("rst_state", 64'(estadoDebug), 64'(OCIOSO));
    #2 reset = 1'b1;

    // OUT 725 with command held, then no re-conversion
    run_out(32'd725, 12'h725, 1'b0, 4);
    @(negedge clock);
    check("out725_state_idle", 64'(estadoDebug), 64'(OCIOSO));
    repeat (14) @(negedge clock);
    check("out725_no_reconv", 64'(pausa), 64'(0));
    check("out725_digits_hold", 64'({centena, dezena, unidade}), 64'(12'h725));

    // IN with button already pressed
    @(posedge clock); #1;
    botaoIN = 1'b1;
    entradaDeDados = 4'hA;
    exp_q.push_back({32'd6, m_bcd, m_est});
    entradaSaidaControl = CMD_IN;
    repeat (4) begin
      @(negedge clock);
      check("inpre_pausa_held", 64'(pausa), 64'(1));
      check("inpre_dl_unchanged", 64'(DadosLidos), 64'(m_dl));
    end
    @(posedge clock); #1 botaoIN = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("inpre_pausa_wait", 64'(pausa), 64'(1));
      check("inpre_dl_wait", 64'(DadosLidos), 64'(m_dl));
    end
    @(posedge clock); #1;
    entradaDeDados = 4'h6;
    botaoIN = 1'b1;
    @(negedge clock);
    check("inpre_pausa_edge", 64'(pausa), 64'(1));
    @(negedge clock);
    check("inpre_pausa_drop", 64'(pausa), 64'(0));
    check("inpre_dl", 64'(DadosLidos), 64'(32'd6));
    m_dl = 32'd6;
    entradaSaidaControl = CMD_NENHUM;
    botaoIN = 1'b0;

    // Saturation
    run_out(32'd1234, 12'h999, 1'b1, 0);

    // Reset in the middle of a conversion of 500
    @(posedge clock); #1;
    entradaSaidaControl = CMD_OUT;
    dadosEscrita = 32'd500;
    repeat (5) @(negedge clock);
    check("abort_converting", 64'(estadoDebug), 64'(CONVERTE));
    #2 reset = 1'b0;
    @(negedge clock);
    check("abort_digits", 64'({centena, dezena, unidade}), 64'(0));
    check("abort_estouro", 64'(estouro), 64'(0));
    check("abort_pausa", 64'(pausa), 64'(0));
    check("abort_dl", 64'(DadosLidos), 64'(0));
    check("abort_state", 64'(estadoDebug), 64'(OCIOSO));
    m_dl = '0;
    m_bcd = '0;
    m_est = 1'b0;
    #2;
    entradaSaidaControl = CMD_NENHUM;
    reset = 1'b1;

    run_out(32'd42, 12'h042, 1'b0, 0);
    run_out(32'd1234, 12'h999, 1'b1, 0);
    run_out(32'd999, 12'h999, 1'b0, 0);
    run_out(32'd0, 12'h000, 1'b0, 0);

    // Button edges in OCIOSO are ignored
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      botaoIN = ~botaoIN;
      entradaDeDados = 4'hF;
      @(negedge clock);
      check("idle_btn_pausa", 64'(pausa), 64'(0));
      check("idle_btn_dl", 64'(DadosLidos), 64'(m_dl));
    end
    @(posedge clock); #1 botaoIN = 1'b0;

    // IN then button toggles while parked in LIBERA
    run_in(4'h9, 4);

    // Reserved command
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      entradaSaidaControl = 2'b11;
      @(negedge clock);
      check("cmd11_pausa", 64'(pausa), 64'(0));
      check("cmd11_state", 64'(estadoDebug), 64'(OCIOSO));
    end
    @(posedge clock); #1 entradaSaidaControl = CMD_NENHUM;

    // Back-to-back IN 3 then OUT 3
    run_in(4'h3, 0);
    run_out(32'd3, 12'h003, 1'b0, 0);
    repeat (3) @(negedge clock);
    check("b2b_dl", 64'(DadosLidos), 64'(32'd3));
    check("b2b_idle", 64'(estadoDebug), 64'(OCIOSO));

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_entrada_saida.md
Name: controle_entrada_saida

Overview:
- I/O controller between the CPU datapath (IN/OUT command decode) and the board switches, push-button and 7-segment digit drivers.
- Services IN by stalling the CPU until a button press, then latching the switch value.
- Services OUT by stalling the CPU while it converts the written word to three BCD digits, saturated at 999.
- Its pause output feeds the CPU's system-halt logic.

Parameters:
- LARGURA_DADO, 32, data word width.
- LARGURA_CHAVES, 4, switch input width.
- BITS_BCD, 10, binary bits converted (covers 0..999).
- MAX_DISPLAY, 999, saturation value.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- entradaSaidaControl  in  2  command: 00 none, 01 IN, 10 OUT, 11 reserved (treated as none).
- dadosEscrita  in  LARGURA_DADO  value to display on OUT (rt).
- entradaDeDados  in  LARGURA_CHAVES  switch value.
- botaoIN  in  1  debounced, active-high button level.
- DadosLidos  out  LARGURA_DADO  zero-extended switch value latched by the last IN.
- pausa  out  1  stall request to the CPU.
- unidade, dezena, centena  out  4 each  BCD digits shown.
- estouro  out  1  last OUT value exceeded MAX_DISPLAY.

Behaviour:
- Clock and reset: one clock (clock). reset is asynchronous and active-low. While reset=0, all state and outputs clear: FSM=OCIOSO, DadosLidos=0, digits=0, estouro=0, pausa=0, botao_ant=0.
- botao_ant registers botaoIN every cycle. Edge detect: sobe = botaoIN & ~botao_ant.
- pausa = (estado==OCIOSO && cmd in {01,10}) || estado in {ESPERA_SOLTA, ESPERA_BOTAO, CONVERTE, ATUALIZA}. pausa is combinational from state and cmd, so the stall starts in the same cycle the command appears.
- State OCIOSO:
  - cmd=01 -> ESPERA_SOLTA.
  - cmd=10 -> CONVERTE. Load bin = min(dadosEscrita, MAX_DISPLAY)[9:0]. Set estouro_pend = (dadosEscrita > MAX_DISPLAY), unsigned compare. Clear the BCD accumulator and cnt=0.
  - Any other cmd: stay in OCIOSO.
- State ESPERA_SOLTA: if botaoIN=0 -> ESPERA_BOTAO. A button already held when IN issues must be released first.
- State ESPERA_BOTAO: on sobe, latch DadosLidos = {zeros, entradaDeDados} -> LIBERA. DadosLidos changes only here.
- State CONVERTE: one double-dabble step per cycle; add 3 to any BCD nibble >=5, then shift in bin MSB. cnt increments; after the step with cnt==BITS_BCD-1 -> ATUALIZA. This is exactly BITS_BCD cycles.
- State ATUALIZA: commit all three digits and estouro together (atomic; no partial digits are ever visible) -> LIBERA.
- State LIBERA: pausa=0. Stay until cmd==00 or cmd==11, then -> OCIOSO. A command held static is therefore serviced exactly once.
- OUT latency: command seen in cycle N; digits update at the clock edge ending cycle N+BITS_BCD+1 (N+11); pausa falls in cycle N+12.
- IN latency: DadosLidos updates at the edge where sobe is sampled; pausa falls the next cycle.
- Button edges outside ESPERA_BOTAO are ignored.
- Digits and DadosLidos hold between commands.
- Reset during any state aborts the operation immediately; no partial digit update occurs.

Decomposition:
- Shared package:
  - command codes CMD_NENHUM=2'b00, CMD_IN=2'b01, CMD_OUT=2'b10;
  - state encoding (OCIOSO, ESPERA_SOLTA, ESPERA_BOTAO, CONVERTE, ATUALIZA, LIBERA);
  - MAX_DISPLAY.
- Sub-module: conversor_bcd_serial, a sequential double-dabble with inputs start, bin[9:0] and outputs pronto, bcd[11:0]. The top FSM sequences it and owns the commit registers.

Test Plan:
- Reset: reset=0 mid-CONVERTE of 500 -> digits 0/0/0, pausa=0, estouro=0. After release, OUT 42 -> digits 0/4/2.
- OUT 725 with cmd held at 10: pausa=1 for 12 cycles. Digits 7/2/5 appear in cycle 11 only, never partial. After cmd returns to 00, FSM is in OCIOSO and no re-conversion occurs.
- OUT 1234 -> digits 9/9/9, estouro=1. Then OUT 999 -> 9/9/9, estouro=0. Then OUT 0 -> 0/0/0.
- IN, button pressed before command: switches=4'hA, botaoIN already 1 -> pausa stays 1 and DadosLidos unchanged. Release, switches=4'h6, press -> DadosLidos=32'd6 and pausa drops the next cycle.
- IN with button toggling while in OCIOSO/LIBERA -> DadosLidos unchanged. cmd=11 for 5 cycles -> pausa=0, no state change.
- Back-to-back: IN (value 3) then OUT 3 with one 00 gap cycle -> DadosLidos=3, digits 0/0/3. Each command serviced once.
